// File: rtl/cos_ci_sequencer.sv
// Initiator for the multi-cycle custom-instruction interface of the cosine unit.
// Takes one float32 operand at a time from a valid/ready stream and issues it as a
// start/dataa transaction. It waits for done and returns the result on a valid/ready
// stream. A watchdog aborts a hung transaction and pulses the unit's reset.
module cos_ci_sequencer #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned TMR_W          = 14,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ci_clk_en,
  output logic              ci_reset,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StRecover} state_t;

  localparam logic [TMR_W-1:0] WdLast = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] watchdog;
  logic             timeout_hit;

  // Accept only in IDLE, and never while reset is held.
  assign in_ready = (state == StIdle) && !aclr;

  // Watchdog expiry; done in the same cycle wins.
  assign timeout_hit = (state == StWait) && !ci_done && (watchdog == WdLast);

  // Sequencer FSM with all interface outputs registered.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state       <= StIdle;
      watchdog    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      ci_clk_en   <= 1'b0;
      ci_reset    <= 1'b0;
      ci_start    <= 1'b0;
      ci_dataa    <= '0;
      err_timeout <= 1'b0;
      op_count    <= '0;
    end else begin
      ci_start <= 1'b0;
      ci_reset <= 1'b0;

      // Sticky error; a new timeout beats a simultaneous clear.
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (in_valid) begin
            ci_dataa  <= in_data;
            ci_start  <= 1'b1;
            ci_clk_en <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          // Done cannot legally arrive in the start cycle, so it is not looked at here.
          watchdog <= '0;
          state    <= StWait;
        end
        StWait: begin
          if (ci_done) begin
            out_data  <= ci_result;
            out_valid <= 1'b1;
            ci_clk_en <= 1'b0;
            state     <= StHold;
          end else if (timeout_hit) begin
            ci_reset  <= 1'b1;
            ci_clk_en <= 1'b0;
            state     <= StRecover;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= StIdle;
          end
        end
        StRecover: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cos_ci_sequencer.sv
// Bench for cos_ci_sequencer: behavioural cosine-unit responder plus a scoreboard of
// expected results (~operand) checked whenever a result is handed off.
module tb_cos_ci_sequencer;

  localparam int DW = 32;
  localparam int TO = 16;
  localparam int TW = 5;
  localparam int CW = 16;

  logic          clk       = 1'b0;
  logic          aclr      = 1'b1;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b1;
  logic          err_clr   = 1'b0;
  logic          ci_done   = 1'b0;
  logic [DW-1:0] ci_result = '0;
  logic          in_ready, out_valid, ci_clk_en, ci_reset, ci_start, err_timeout;
  logic [DW-1:0] out_data, ci_dataa;
  logic [CW-1:0] op_count;

  cos_ci_sequencer #(
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO),
    .TMR_W         (TW),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ci_clk_en  (ci_clk_en),
    .ci_reset   (ci_reset),
    .ci_start   (ci_start),
    .ci_dataa   (ci_dataa),
    .ci_result  (ci_result),
    .ci_done    (ci_done),
    .err_clr    (err_clr),
    .err_timeout(err_timeout),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int            passed = 0;
  int            total = 0;
  logic [DW-1:0] exp_q[$];
  int            resp_delay = 5;
  bit            never_done = 1'b0;
  int            resp_cnt = 0;
  logic [DW-1:0] resp_dataa = '0;
  int            busy_viol = 0;
  int            start_run = 0;
  int            max_start_run = 0;
  int            start_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Responder: done one cycle wide, resp_delay cycles after the start cycle.
  always @(negedge clk) begin
    ci_done = 1'b0;
    if (aclr || ci_reset) begin
      resp_cnt = 0;
    end else if (ci_start) begin
      resp_cnt   = resp_delay;
      resp_dataa = ci_dataa;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && !never_done) begin
        ci_done   = 1'b1;
        ci_result = ~resp_dataa;
      end
    end
  end

  // Monitor: busy invariant, start pulse width, scoreboard on output handshake.
  always @(negedge clk) begin
    if (!aclr) begin
      if (in_ready && (ci_clk_en || out_valid || ci_reset)) busy_viol++;
      if (ci_start) begin
        start_total++;
        start_run++;
        if (start_run > max_start_run) max_start_run = start_run;
      end else begin
        start_run = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q.pop_front());
        else check_eq("unexpected_out", out_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit expect_out);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("send_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_out) exp_q.push_back(~d);
    tick();
    in_valid = 1'b0;
  endtask

  // Call in the cycle after the handshake; n = cycles since the handshake cycle.
  task automatic wait_out(input int lim, output int n);
    n = 1;
    while (!out_valid && n < lim) begin
      tick();
      n++;
    end
    if (!out_valid) check_eq("wait_out_timeout", out_valid, 1);
  endtask

  task automatic run_timeout(input bit clr_held, input logic [CW-1:0] cnt_exp);
    int n;
    never_done = 1'b1;
    err_clr    = clr_held;
    send(32'h3F000000, 1'b0);
    n = 1;
    while (!ci_reset && n < 60) begin
      tick();
      n++;
    end
    check_eq("timeout_latency", n, TO + 2);
    check_eq("err_set", err_timeout, 1);
    check_eq("recover_clk_en", ci_clk_en, 0);
    check_eq("recover_no_out", out_valid, 0);
    tick();
    check_eq("reset_one_cycle", ci_reset, 0);
    check_eq("idle_after_recover", in_ready, 1);
    check_eq("count_kept", op_count, cnt_exp);
    if (clr_held) begin
      check_eq("err_cleared_held", err_timeout, 0);
    end else begin
      tick();
      tick();
      check_eq("err_sticky", err_timeout, 1);
      err_clr = 1'b1;
      tick();
      check_eq("err_cleared", err_timeout, 0);
    end
    err_clr    = 1'b0;
    never_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int            n;
    int            s0;
    int            hold_bad;
    logic [DW-1:0] vals[4];
    vals[0] = 32'h3F800000;
    vals[1] = 32'hBF000000;
    vals[2] = 32'h00000000;
    vals[3] = 32'h40490FDB;

    // Reset state
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_start", ci_start, 0);
    check_eq("rst_clk_en", ci_clk_en, 0);
    check_eq("rst_ci_reset", ci_reset, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_count", op_count, 0);
    check_eq("rst_dataa", ci_dataa, 0);
    aclr = 1'b0;
    #1;
    check_eq("ready_after_rst", in_ready, 1);

    // Single operation, latency and start pulse
    send(32'h3E800000, 1'b1);
    check_eq("start_pulse", ci_start, 1);
    check_eq("clk_en_issue", ci_clk_en, 1);
    check_eq("dataa", ci_dataa, 32'h3E800000);
    check_eq("ready_busy", in_ready, 0);
    wait_out(50, n);
    check_eq("latency", n, 7);
    check_eq("out_data_t1", out_data, 32'hC17FFFFF);
    tick();
    check_eq("count_1", op_count, 1);
    check_eq("idle_after_out", in_ready, 1);

    // Back-to-back operands
    for (int i = 0; i < 4; i++) send(vals[i], 1'b1);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check_eq("b2b_drained", exp_q.size(), 0);
    check_eq("count_5", op_count, 5);

    // Backpressure
    out_ready = 1'b0;
    send(32'h40490FDB, 1'b1);
    wait_out(50, n);
    s0       = start_total;
    hold_bad = 0;
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || out_data !== ~32'h40490FDB || in_ready) hold_bad++;
      tick();
    end
    in_valid = 1'b0;
    check_eq("hold_stable", hold_bad, 0);
    check_eq("no_second_start", start_total, s0);
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("count_6", op_count, 6);
    check_eq("hold_drained", exp_q.size(), 0);

    // Timeouts: sticky then clear, and set beating a held clear
    run_timeout(1'b0, 6);
    run_timeout(1'b1, 6);

    // Done on the last watchdog cycle
    resp_delay = TO;
    send(32'h3F400000, 1'b1);
    wait_out(60, n);
    check_eq("late_done_latency", n, TO + 2);
    check_eq("late_done_no_err", err_timeout, 0);
    tick();
    check_eq("count_7", op_count, 7);

    // Reset mid-transaction
    resp_delay = 5;
    send(32'hAAAA5555, 1'b0);
    tick();
    tick();
    check_eq("in_wait", ci_clk_en, 1);
    aclr = 1'b1;
    #1;
    check_eq("aclr_clk_en", ci_clk_en, 0);
    check_eq("aclr_dataa", ci_dataa, 0);
    check_eq("aclr_count", op_count, 0);
    check_eq("aclr_in_ready", in_ready, 0);
    check_eq("aclr_out_valid", out_valid, 0);
    tick();
    aclr = 1'b0;
    #1;
    check_eq("ready_post_aclr", in_ready, 1);
    send(32'h3F800000, 1'b1);
    wait_out(50, n);
    check_eq("post_aclr_latency", n, 7);
    tick();
    check_eq("count_restart", op_count, 1);

    // Global invariants
    tick();
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("busy_ready_low", busy_viol, 0);
    check_eq("start_width", max_start_run, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
